// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with fixed-burst and locked-sequence
// ownership hold.
//
// Ports:
//   h_clk          clock, rising edge
//   h_resetn       asynchronous active-low reset
//   h_busreq       per-master bus request
//   h_lock         per-master locked-sequence request
//   h_trans        transfer type of the address-phase owner
//   h_burst        burst type of the address-phase owner
//   h_ready        transfer done; nothing moves while low
//   h_grant        registered one-hot grant
//   h_master       address-phase owner index (address/control mux select)
//   h_master_data  data-phase owner index (wdata mux select)
//   h_mastlock     current address phase is part of a locked sequence
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_PARK   | nobody requests, grant parked on master 0
// ST_OWN    | granted master may transfer, re-arbitrate on every ready
// ST_BURST  | fixed-length burst running, grant frozen until last beat
// ST_LOCKED | owner holds h_lock, grant frozen until lock drops on IDLE

module ahb_arbiter #(
   parameter int NUM_MST      = 4,
   parameter int MST_ID_WIDTH = 2,
   parameter int HBURST_WIDTH = 3
) (
   input  logic                    h_clk,
   input  logic                    h_resetn,
   input  logic [NUM_MST-1:0]      h_busreq,
   input  logic [NUM_MST-1:0]      h_lock,
   input  logic [1:0]              h_trans,
   input  logic [HBURST_WIDTH-1:0] h_burst,
   input  logic                    h_ready,
   output logic [NUM_MST-1:0]      h_grant,
   output logic [MST_ID_WIDTH-1:0] h_master,
   output logic [MST_ID_WIDTH-1:0] h_master_data,
   output logic                    h_mastlock
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_PARK   = 2'd0,
      ST_OWN    = 2'd1,
      ST_BURST  = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [NUM_MST-1:0]      grant_nxt;
   logic [MST_ID_WIDTH-1:0] rr_ptr, ptr_nxt;
   logic [MST_ID_WIDTH-1:0] grant_idx, win_idx;
   logic                    win_found;
   logic [MST_ID_WIDTH:0]   cand;
   logic [3:0]              beat_cnt, cnt_nxt, burst_load;

   // Remaining SEQ beats after the NONSEQ; zero means no fixed length.
   always_comb begin
      burst_load = 4'd0;
      case (h_burst)
         HBURST_WIDTH'(2), HBURST_WIDTH'(3): burst_load = 4'd3;
         HBURST_WIDTH'(4), HBURST_WIDTH'(5): burst_load = 4'd7;
         HBURST_WIDTH'(6), HBURST_WIDTH'(7): burst_load = 4'd15;
         default:                            burst_load = 4'd0;
      endcase
   end

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_MST; i++)
         if (h_grant[i]) grant_idx = MST_ID_WIDTH'(i);
   end

   // First requester at or after rr_ptr, wrapping; rr_ptr is always < NUM_MST
   // so a single conditional subtract is enough for the wrap.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         cand = {1'b0, rr_ptr} + (MST_ID_WIDTH+1)'(i);
         if (cand >= (MST_ID_WIDTH+1)'(NUM_MST))
            cand = cand - (MST_ID_WIDTH+1)'(NUM_MST);
         if (!win_found && h_busreq[cand[MST_ID_WIDTH-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[MST_ID_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = h_grant;
      ptr_nxt   = rr_ptr;
      cnt_nxt   = beat_cnt;
      if (h_ready) begin
         if (h_trans == TRANS_NONSEQ)
            cnt_nxt = burst_load;
         else if (h_trans == TRANS_SEQ && beat_cnt != 4'd0)
            cnt_nxt = beat_cnt - 4'd1;

         case (state)
            ST_PARK, ST_OWN: begin
               // Lock and fixed bursts freeze the current grant before any
               // re-arbitration is considered.
               if (h_lock[grant_idx]) begin
                  state_nxt = ST_LOCKED;
               end else if (h_trans == TRANS_NONSEQ && burst_load != 4'd0) begin
                  state_nxt = ST_BURST;
               end else if (win_found) begin
                  state_nxt          = ST_OWN;
                  grant_nxt          = '0;
                  grant_nxt[win_idx] = 1'b1;
                  ptr_nxt = (win_idx == MST_ID_WIDTH'(NUM_MST-1)) ? '0
                          : win_idx + MST_ID_WIDTH'(1);
               end else begin
                  state_nxt = ST_PARK;
                  grant_nxt = NUM_MST'(1);
               end
            end
            ST_BURST: begin
               if (h_trans == TRANS_SEQ && beat_cnt == 4'd1)
                  state_nxt = ST_OWN;
            end
            ST_LOCKED: begin
               if (!h_lock[grant_idx] && h_trans == TRANS_IDLE)
                  state_nxt = ST_OWN;
            end
            default: state_nxt = ST_PARK;
         endcase
      end
   end

   always_ff @(posedge h_clk or negedge h_resetn) begin
      if (!h_resetn) begin
         state         <= ST_PARK;
         h_grant       <= NUM_MST'(1);
         rr_ptr        <= '0;
         beat_cnt      <= 4'd0;
         h_master      <= '0;
         h_master_data <= '0;
         h_mastlock    <= 1'b0;
      end else begin
         state    <= state_nxt;
         h_grant  <= grant_nxt;
         rr_ptr   <= ptr_nxt;
         beat_cnt <= cnt_nxt;
         if (h_ready) begin
            h_master      <= grant_idx;
            h_master_data <= h_master;
            h_mastlock    <= h_lock[grant_idx];
         end
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (NUM_MST=4): parking, round-robin, fixed
// burst hold with wait states, locked sequence, async reset mid-burst.
module tb_ahb_arbiter;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic       h_clk = 1'b0;
   logic       h_resetn;
   logic [3:0] h_busreq;
   logic [3:0] h_lock;
   logic [1:0] h_trans;
   logic [2:0] h_burst;
   logic       h_ready;
   logic [3:0] h_grant;
   logic [1:0] h_master;
   logic [1:0] h_master_data;
   logic       h_mastlock;

   int n_cmp = 0;
   int n_err = 0;

   ahb_arbiter #(.NUM_MST(4), .MST_ID_WIDTH(2), .HBURST_WIDTH(3)) dut (
      .h_clk         (h_clk),
      .h_resetn      (h_resetn),
      .h_busreq      (h_busreq),
      .h_lock        (h_lock),
      .h_trans       (h_trans),
      .h_burst       (h_burst),
      .h_ready       (h_ready),
      .h_grant       (h_grant),
      .h_master      (h_master),
      .h_master_data (h_master_data),
      .h_mastlock    (h_mastlock)
   );

   always #5 h_clk = ~h_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] m,
                          input logic [1:0] md, input logic ml);
      chk({tag, ".grant"},    32'(h_grant),       32'(g));
      chk({tag, ".master"},   32'(h_master),      32'(m));
      chk({tag, ".mdata"},    32'(h_master_data), 32'(md));
      chk({tag, ".mastlock"}, 32'(h_mastlock),    32'(ml));
   endtask

   task automatic step();
      @(posedge h_clk);
      #1;
   endtask

   task automatic apply_reset();
      h_resetn = 1'b0;
      h_busreq = '0;
      h_lock   = '0;
      h_trans  = T_IDLE;
      h_burst  = 3'b000;
      h_ready  = 1'b1;
      repeat (2) step();
      h_resetn = 1'b1;
   endtask

   logic [9:0] rdy_pat;

   initial begin
      // reset state
      apply_reset();
      chk_out("rst", 4'b0001, 2'd0, 2'd0, 1'b0);

      // no requests: parked on master 0
      for (int c = 0; c < 10; c++) begin
         step();
         chk("park.grant",  32'(h_grant),  32'h1);
         chk("park.master", 32'(h_master), 32'h0);
      end

      // round-robin between masters 1 and 2, one wait state in the middle
      apply_reset();
      h_busreq = 4'b0110;
      step(); chk_out("rr1", 4'b0010, 2'd0, 2'd0, 1'b0);
      step(); chk_out("rr2", 4'b0100, 2'd1, 2'd0, 1'b0);
      step(); chk_out("rr3", 4'b0010, 2'd2, 2'd1, 1'b0);
      h_ready = 1'b0;
      step(); chk_out("rr_wait", 4'b0010, 2'd2, 2'd1, 1'b0);
      h_ready = 1'b1;
      step(); chk_out("rr4", 4'b0100, 2'd1, 2'd2, 1'b0);
      step(); chk_out("rr5", 4'b0010, 2'd2, 2'd1, 1'b0);

      // master 2 INCR8 with master 3 waiting, three wait states inside
      apply_reset();
      h_busreq = 4'b0100;
      step(); chk("b8.grant1", 32'(h_grant), 32'h4);
      step(); chk("b8.sticky", 32'(h_grant), 32'h4);
      chk("b8.master", 32'(h_master), 32'h2);
      h_trans  = T_NONSEQ;
      h_burst  = 3'b101;
      h_busreq = 4'b1100;
      step(); chk("b8.nonseq", 32'(h_grant), 32'h4);
      h_trans  = T_SEQ;
      h_busreq = 4'b1000;
      rdy_pat  = 10'b1011011011;
      for (int c = 0; c < 10; c++) begin
         h_ready = rdy_pat[c];
         step();
         chk("b8.hold", 32'(h_grant), 32'h4);
      end
      h_ready = 1'b1;
      h_trans = T_IDLE;
      step(); chk("b8.handover", 32'(h_grant), 32'h8);
      step(); chk("b8.newmaster", 32'(h_master), 32'h3);

      // locked sequence by master 1 while masters 0 and 3 request
      apply_reset();
      h_busreq = 4'b0010;
      step(); chk("lk.grant", 32'(h_grant), 32'h2);
      h_lock   = 4'b0010;
      h_busreq = 4'b1011;
      step(); chk_out("lk.enter", 4'b0010, 2'd1, 2'd0, 1'b1);
      h_trans = T_NONSEQ;
      h_burst = 3'b000;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("lk.grant_hold", 32'(h_grant),    32'h2);
         chk("lk.mastlock",   32'(h_mastlock), 32'h1);
      end
      h_lock = 4'b0000;
      step(); chk("lk.nonidle_hold", 32'(h_grant), 32'h2);
      chk("lk.mastlock_drop", 32'(h_mastlock), 32'h0);
      h_trans = T_IDLE;
      step(); chk("lk.exit", 32'(h_grant), 32'h2);
      step(); chk("lk.next", 32'(h_grant), 32'h8);

      // async reset in the middle of a WRAP4
      apply_reset();
      h_busreq = 4'b0010;
      step();
      step();
      h_trans = T_NONSEQ;
      h_burst = 3'b010;
      step();
      h_trans = T_SEQ;
      step(); chk("w4.cnt_mid", 32'(dut.beat_cnt), 32'h2);
      chk("w4.grant_mid", 32'(h_grant), 32'h2);
      #2 h_resetn = 1'b0;
      #1;
      chk_out("w4.rst_async", 4'b0001, 2'd0, 2'd0, 1'b0);
      chk("w4.cnt_rst", 32'(dut.beat_cnt), 32'h0);
      h_busreq = 4'b0000;
      h_trans  = T_IDLE;
      step();
      h_resetn = 1'b1;
      step(); chk_out("w4.after", 4'b0001, 2'd0, 2'd0, 1'b0);
      chk("w4.cnt_after", 32'(dut.beat_cnt), 32'h0);
      h_busreq = 4'b0010;
      h_trans  = T_SEQ;
      step(); chk("w4.rearb", 32'(h_grant), 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
